// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } bridge_state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are answered OKAY with no wait.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one AHB transfer becomes one APB setup+access,
// with PSLVERR, sub-word writes and PREADY timeouts reported as a two-cycle AHB ERROR.
module ahb_to_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic                      HREADY,
    output logic [DATA_WIDTH-1:0]     HRDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic                      PWRITE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    bridge_state_e             state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [15:0]               cnt_q, cnt_d;

    logic accept;
    logic can_accept;
    logic sub_word_wr;

    // Upper AHB address bits select the bridge at the interconnect and are not forwarded.
    logic unused_haddr;
    assign unused_haddr = ^HADDR[AHB_ADDR_WIDTH-1:APB_ADDR_WIDTH];

    assign accept      = HSEL & is_active(HTRANS) & HREADY;
    assign sub_word_wr = HWRITE & (HSIZE != HSIZE_WORD);

    assign PADDR  = addr_q;
    assign PWRITE = write_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        can_accept = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWDATA     = wdata_q;
        HRDATA     = rdata_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;

        case (state_q)
            ST_IDLE: can_accept = 1'b1;
            ST_SETUP: begin
                PSEL      = 1'b1;
                HREADYOUT = 1'b0;
                PWDATA    = HWDATA;
                wdata_d   = HWDATA;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    if (PSLVERR) begin
                        HREADYOUT = 1'b0;
                        state_d   = ST_ERR1;
                    end else begin
                        can_accept = 1'b1;
                        state_d    = ST_IDLE;
                        if (!write_q) begin
                            HRDATA  = PRDATA;
                            rdata_d = PRDATA;
                        end
                    end
                end else begin
                    HREADYOUT = 1'b0;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP      = HRESP_ERROR;
                can_accept = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new transfer may only be taken in a cycle where HREADYOUT is high.
        if (can_accept && accept) begin
            addr_d  = HADDR[APB_ADDR_WIDTH-1:0];
            write_d = HWRITE;
            if (sub_word_wr) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_SETUP;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed table-driven bench for ahb_to_apb_bridge, built with TIMEOUT_CYCLES=4.
module tb_ahb_to_apb_bridge;
    import ahb_apb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        PSEL;
    logic        PENABLE;
    logic [8:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_to_apb_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        string       name;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        int          exp_stalls;
        logic        exp_resp;
        logic        exp_psel;
        logic [8:0]  exp_paddr;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input string name, input logic hwrite, input logic [2:0] hsize,
                                input logic [31:0] haddr, input logic [31:0] hwdata,
                                input logic [31:0] prdata, input int waits, input logic slverr,
                                input int exp_stalls, input logic exp_resp, input logic exp_psel,
                                input logic [8:0] exp_paddr);
        vec_t v;
        v.name = name; v.hwrite = hwrite; v.hsize = hsize; v.haddr = haddr;
        v.hwdata = hwdata; v.prdata = prdata; v.waits = waits; v.slverr = slverr;
        v.exp_stalls = exp_stalls; v.exp_resp = exp_resp; v.exp_psel = exp_psel;
        v.exp_paddr = exp_paddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        HREADY = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    // One AHB transfer with a scheduled APB responder: PREADY rises in data-phase cycle 2+waits.
    task automatic run_vec(input vec_t v);
        bit          done = 1'b0;
        bit          psel_seen = 1'b0;
        bit          pen_seen = 1'b0;
        int          stalls = 0;
        logic [8:0]  paddr_cap = '0;
        logic        pwrite_cap = 1'b0;
        logic [31:0] pwdata_cap = '0;
        logic        resp_fin = 1'b0;
        logic [31:0] hrdata_fin = '0;
        bit          ok_read = !v.hwrite && !v.exp_resp;

        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = v.haddr; HWRITE = v.hwrite;
        HSIZE = v.hsize; HREADY = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = v.prdata;
        @(negedge HCLK);
        check({v.name, "/addr_hreadyout"}, 32'(HREADYOUT), 32'h1);
        next_cycle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = v.hwdata;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            if (cyc >= 2) HWDATA = 32'hBAD0_BAD0;
            PREADY  = (cyc == 2 + v.waits);
            PSLVERR = PREADY & v.slverr;
            @(negedge HCLK);
            if (cyc == 1)
                check({v.name, "/cyc1_psel_penable"}, 32'({PSEL, PENABLE}),
                      v.exp_psel ? 32'h2 : 32'h0);
            if (PSEL) psel_seen = 1'b1;
            if (PSEL && PENABLE && !pen_seen) begin
                pen_seen = 1'b1; paddr_cap = PADDR; pwrite_cap = PWRITE; pwdata_cap = PWDATA;
            end
            if (HRESP && !HREADYOUT) check({v.name, "/err1_psel"}, 32'(PSEL), 32'h0);
            if (HREADYOUT) begin
                done = 1'b1; stalls = cyc - 1; resp_fin = HRESP; hrdata_fin = HRDATA;
            end
            next_cycle();
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        check({v.name, "/completed"}, 32'(done), 32'h1);
        check({v.name, "/stall_cycles"}, 32'(stalls), 32'(v.exp_stalls));
        check({v.name, "/hresp"}, 32'(resp_fin), 32'(v.exp_resp));
        check({v.name, "/psel_seen"}, 32'(psel_seen), 32'(v.exp_psel));
        if (v.exp_psel) begin
            check({v.name, "/paddr"}, 32'(paddr_cap), 32'(v.exp_paddr));
            check({v.name, "/pwrite"}, 32'(pwrite_cap), 32'(v.hwrite));
            if (v.hwrite) check({v.name, "/pwdata"}, pwdata_cap, v.hwdata);
        end
        if (ok_read) check({v.name, "/hrdata"}, hrdata_fin, v.prdata);
        @(negedge HCLK);
        check({v.name, "/post_idle"}, 32'({PSEL, HREADYOUT, HRESP}), 32'h2);
        if (ok_read) check({v.name, "/hrdata_held"}, HRDATA, v.prdata);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("wr_word",     1'b1, 3'b010, 32'h0000_0004, 32'h0000_0010, 32'h0,          0,   1'b0, 1, 1'b0, 1'b1, 9'h004);
        vecs[1] = mk("rd_wait3",    1'b0, 3'b010, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 3,   1'b0, 4, 1'b0, 1'b1, 9'h008);
        vecs[2] = mk("rd_slverr",   1'b0, 3'b010, 32'h0000_000C, 32'h0,          32'h1111_2222, 0,   1'b1, 3, 1'b1, 1'b1, 9'h00C);
        vecs[3] = mk("wr_byte",     1'b1, 3'b000, 32'h0000_0010, 32'h0000_00AA, 32'h0,          0,   1'b0, 1, 1'b1, 1'b0, 9'h000);
        vecs[4] = mk("wr_timeout",  1'b1, 3'b010, 32'h0000_0014, 32'h1234_0000, 32'h0,          100, 1'b0, 6, 1'b1, 1'b1, 9'h014);
        vecs[5] = mk("wr_trunc",    1'b1, 3'b010, 32'hFFFF_F1FC, 32'hCAFE_F00D, 32'h0,          1,   1'b0, 2, 1'b0, 1'b1, 9'h1FC);
        vecs[6] = mk("rd_byte",     1'b0, 3'b000, 32'h0000_0020, 32'h0,          32'h1234_5678, 0,   1'b0, 1, 1'b0, 1'b1, 9'h020);
        vecs[7] = mk("rd_wait2",    1'b0, 3'b010, 32'h0000_0100, 32'h0,          32'hA5A5_5A5A, 2,   1'b0, 3, 1'b0, 1'b1, 9'h100);
        vecs[8] = mk("wr_slverr_w", 1'b1, 3'b010, 32'h0000_0030, 32'h0BAD_F00D, 32'h0,          2,   1'b1, 5, 1'b1, 1'b1, 9'h030);

        // Reset values
        drive_idle();
        HWDATA = '0; PRDATA = '0;
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("reset/psel_penable_pwrite", 32'({PSEL, PENABLE, PWRITE}), 32'h0);
        check("reset/paddr", 32'(PADDR), 32'h0);
        check("reset/pwdata", PWDATA, 32'h0);
        check("reset/hrdata", HRDATA, 32'h0);
        check("reset/hreadyout_hresp", 32'({HREADYOUT, HRESP}), 32'h2);
        next_cycle();
        HRESETn = 1'b1;
        next_cycle();

        // Non-transfers: BUSY, IDLE and a NONSEQ with HREADY low must be ignored with OKAY
        for (int i = 0; i < 3; i++) begin
            HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'b000; HADDR = 32'h40;
            HTRANS = (i == 0) ? HTRANS_BUSY : (i == 1) ? HTRANS_IDLE : HTRANS_NONSEQ;
            HREADY = (i != 2);
            @(negedge HCLK);
            check($sformatf("ignore%0d/now", i), 32'({PSEL, HREADYOUT, HRESP}), 32'h2);
            next_cycle();
            drive_idle();
            @(negedge HCLK);
            check($sformatf("ignore%0d/next", i), 32'({PSEL, HREADYOUT, HRESP}), 32'h2);
            next_cycle();
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back write then read; reset during the read's ACCESS
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h4; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        next_cycle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h55;
        @(negedge HCLK);
        check("b2b/wr_setup", 32'({PSEL, PENABLE}), 32'h2);
        next_cycle();
        PREADY = 1'b1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h8; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        @(negedge HCLK);
        check("b2b/wr_access", 32'({PSEL, PENABLE, HREADYOUT, PWDATA[7:0]}), 32'h755);
        next_cycle();
        drive_idle();
        @(negedge HCLK);
        check("b2b/rd_setup", 32'({PSEL, PENABLE, PWRITE, PADDR}), 32'h808);
        next_cycle();
        @(negedge HCLK);
        check("b2b/rd_access", 32'({PSEL, PENABLE, HREADYOUT}), 32'h6);
        #1 HRESETn = 1'b0;
        #1 check("b2b/reset_abandon", 32'({PSEL, PENABLE, HREADYOUT, HRESP}), 32'h2);
        next_cycle();
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("b2b/after_reset_idle", 32'({PSEL, PENABLE, HREADYOUT, HRESP}), 32'h2);
        next_cycle();

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
